// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction fetch FSM. Issues word-indexed requests to instruction memory,
//   captures the returned instruction and offers it downstream with a
//   valid/ready handshake. A redirect strobe replaces the PC at any point; a
//   request already in flight is allowed to complete, and its data is dropped.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   run                   allow new requests while high
//   redir_en/redir_target one-cycle PC redirect and its target word index
//   imem_req/imem_addr    memory request and word index (held until ack)
//   imem_ack/imem_rdata   memory completion and returned instruction
//   instr_valid/ready     downstream handshake
//   instr_data/instr_pc   offered instruction and its word index
//   fetch_count           number of instructions accepted downstream
//   busy                  FSM not in IDLE
module fetch_sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         INSTR_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               redir_en,
    input  logic [7:0]         redir_target,
    output logic               imem_req,
    output logic [7:0]         imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [7:0]         instr_pc,
    output logic [15:0]        fetch_count,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, HOLD} state_t;

    state_t             state_q, state_d;
    logic [7:0]         pc_q, pc_d;
    logic [7:0]         addr_q, addr_d;
    logic [7:0]         ipc_q, ipc_d;
    logic [INSTR_W-1:0] data_q, data_d;
    logic [15:0]        cnt_q, cnt_d;
    state_t             after_q;  // where to go once the current item is done

    // Leaving REQ/DRAIN/HOLD returns to REQ only if run still allows it.
    assign after_q = run ? REQ : IDLE;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        data_d  = data_q;
        cnt_d   = cnt_q;

        // Redirect is checked first in every state so it beats ack/ready.
        case (state_q)
            IDLE: begin
                if (redir_en)  pc_d    = redir_target;
                else if (run)  state_d = REQ;
            end
            REQ: begin
                if (redir_en) begin
                    pc_d    = redir_target;
                    // Without an ack the old request is still outstanding.
                    state_d = imem_ack ? after_q : DRAIN;
                end else if (imem_ack) begin
                    data_d  = imem_rdata;
                    ipc_d   = pc_q;
                    pc_d    = pc_q + 8'd1;
                    state_d = HOLD;
                end
            end
            DRAIN: begin
                if (redir_en)      pc_d    = redir_target;
                else if (imem_ack) state_d = after_q;
            end
            HOLD: begin
                if (redir_en) begin
                    pc_d    = redir_target;
                    state_d = after_q;
                end else if (instr_ready) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = after_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The request address is latched on entry to REQ so DRAIN keeps
    // presenting the old address while pc already holds the redirect.
    assign addr_d = (state_d == REQ) ? pc_d : addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            ipc_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ipc_q   <= ipc_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_req    = (state_q == REQ) || (state_q == DRAIN);
    assign imem_addr   = addr_q;
    assign instr_valid = (state_q == HOLD);
    assign instr_data  = data_q;
    assign instr_pc    = ipc_q;
    assign fetch_count = cnt_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 8'h00, SHALL be the word index loaded into the PC at reset.
REQ-002 Parameter INSTR_W, default 32, SHALL be the instruction width.
REQ-003 Ports SHALL be as follows:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- run  in  1  enables fetching while high.
- redir_en  in  1  one-cycle PC redirect strobe from branch/jump logic.
- redir_target  in  8  redirect word index.
- imem_req  out  1  instruction memory request.
- imem_addr  out  8  requested word index.
- imem_ack  in  1  memory completes the request; imem_rdata is valid this cycle.
- imem_rdata  in  INSTR_W  fetched instruction.
- instr_valid  out  1  instruction offered downstream.
- instr_ready  in  1  downstream accepts the instruction.
- instr_data  out  INSTR_W  offered instruction.
- instr_pc  out  8  word index of instr_data.
- fetch_count  out  16  count of delivered instructions.
- busy  out  1  high in any state other than IDLE.

Function
REQ-004 The FSM SHALL have four states: IDLE, REQ, DRAIN and HOLD; all outputs SHALL be registered or decoded from state and registers only.
REQ-005 IDLE: imem_req=0 and instr_valid=0; if run=1, the next state SHALL be REQ.
REQ-006 REQ: imem_req=1 and imem_addr=pc; imem_addr SHALL stay stable until the imem_ack cycle.
REQ-007 REQ with imem_ack=1 and redir_en=0 SHALL do all of the following:
- register imem_rdata into instr_data and pc into instr_pc;
- set pc to pc+1, modulo 256 (8'hFF wraps to 8'h00);
- enter HOLD with instr_valid=1 on the next cycle.
REQ-008 The minimum latency SHALL be 1 cycle from the ack cycle to instr_valid=1.
REQ-009 HOLD: instr_valid=1; instr_data and instr_pc SHALL stay stable until the instr_ready=1 cycle.
REQ-010 HOLD with instr_ready=1 SHALL increment fetch_count by 1 (wrapping at 16'hFFFF), then:
- go to REQ if run=1;
- go to IDLE if run=0.
REQ-011 redir_en in IDLE SHALL load pc with redir_target; the state is otherwise unchanged.
REQ-012 redir_en in REQ with imem_ack=1 SHALL discard imem_rdata, load pc with redir_target and go to REQ (run=1) or IDLE (run=0).
REQ-013 redir_en in REQ with imem_ack=0 SHALL load pc with redir_target and go to DRAIN.
REQ-014 DRAIN SHALL:
- hold imem_req=1 with the old address;
- discard the data on imem_ack;
- then go to REQ (run=1) or IDLE (run=0).
REQ-015 redir_en in DRAIN SHALL overwrite pc with the newest redir_target; the state is unchanged.
REQ-016 redir_en in HOLD SHALL deassert instr_valid on the next cycle without incrementing fetch_count, even if instr_ready=1 in the same cycle, and load pc with redir_target.
REQ-017 Redirect SHALL take precedence over imem_ack and instr_ready in every state.
REQ-018 run=0 SHALL NOT abort an outstanding request or a held instruction; it only prevents a new REQ.
REQ-019 imem_ack outside REQ and DRAIN SHALL be ignored.

Reset
REQ-020 rst_n=0 SHALL immediately force the following, regardless of clk and mid-transaction:
- state=IDLE, pc=RESET_PC;
- imem_req=0, imem_addr=RESET_PC;
- instr_valid=0, instr_data=0, instr_pc=0;
- fetch_count=0, busy=0.
REQ-021 After rst_n rises, the first imem_req SHALL occur no earlier than 1 cycle after run=1 is sampled.

Verification
REQ-022 Reset, run=1, ack 1 cycle after each request with rdata=32'hA000_0000+addr, ready tied 1 -> instr_pc sequence 0,1,2,3; instr_data 32'hA000_0000..32'hA000_0003; fetch_count=4.
REQ-023 pc=8'hFF fetched and accepted -> next imem_addr=8'h00, instr_pc=8'hFF, no stall.
REQ-024 redir_en with target 8'h40 while in REQ and ack delayed 3 cycles -> imem_addr holds the old value until the ack; that data is dropped; the next request address is 8'h40; no instr_valid for the old address.
REQ-025 instr_ready=0 for 5 cycles in HOLD -> instr_valid, instr_data and instr_pc are stable for all 5 cycles; fetch_count increments once, on the cycle ready=1.
REQ-026 redir_en and instr_ready both high in HOLD with target 8'h10 -> instr_valid=0 next cycle, fetch_count unchanged, next imem_addr=8'h10.
REQ-027 rst_n pulsed low while in DRAIN -> all outputs reach reset values asynchronously; a late imem_ack after reset is ignored; run=1 resumes at RESET_PC.
